// File: rtl/alu_mul.sv
// Sequential signed 8x8 radix-2 Booth multiplier with a start/done handshake.
// Optional ALU_MUL_ZERO_SKIP_EN: zero operands complete at the accepting edge.
module alu_mul (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  acc_q, acc_d, m_q, m_d, sum;
  logic [7:0]  q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] prod_q, prod_d;
  logic        done_q, done_d;

  // 9-bit accumulator keeps A-M in range even for M = -128
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          q_d     = b;
          qm1_d   = 1'b0;
          m_d     = {a[7], a};
          cnt_d   = '0;
          state_d = CALC;
`ifdef ALU_MUL_ZERO_SKIP_EN
          if (a == 8'd0 || b == 8'd0) begin
            prod_d  = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        acc_d = {sum[8], sum[8:1]};
        q_d   = {sum[0], q_q[7:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          prod_d  = {acc_d[7:0], q_d};
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign product = prod_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_alu_mul.sv
// Directed self-checking bench for alu_mul: signed products, latency, hold, reset.
module tb_alu_mul;

  logic        clk, reset, start;
  logic [7:0]  a, b;
  logic [15:0] product;
  logic        done, busy;
  int          n_chk, n_err;

  alu_mul dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .product(product), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_MUL_ZERO_SKIP_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 8;
`endif

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge, then time done from the accepting edge.
  task automatic do_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [15:0] exp, input int lat);
    logic [15:0] prev;
    int n;
    @(negedge clk);
    prev = product;
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'h5A; b = 8'hA5;
    chk({tag, "_busy"}, 16'(busy), 16'd1);
    if (!done) chk({tag, "_hold"}, product, prev);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 16'(n), 16'(lat));
    chk({tag, "_prod"}, product, exp);
    @(posedge clk); #1;
    chk({tag, "_donefall"}, 16'(done), 16'd0);
    chk({tag, "_idle"}, 16'(busy), 16'd0);
    chk({tag, "_keep"}, product, exp);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_prod", product, 16'h0000);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    @(negedge clk); reset = 1'b0;

    do_op("m7xm3",   8'd7,   8'hFD, 16'hFFEB, 8);
    do_op("m128sq",  8'h80,  8'h80, 16'h4000, 8);
    do_op("m127x128",8'd127, 8'h80, 16'hC080, 8);
    do_op("mm1x1",   8'hFF,  8'd1,  16'hFFFF, 8);
    do_op("zero",    8'd0,   8'hB3, 16'h0000, ZLAT);
    do_op("m12x11",  8'd12,  8'd11, 16'd132,  8);
    do_op("mm9x9",   8'hF7,  8'd9,  16'hFFAF, 8);

    // start held high, operands churning during the operation
    @(negedge clk); a = 8'd3; b = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      if (k < 8) chk("hold_nodone", 16'(done), 16'd0);
      if (k == 8) begin
        chk("hold_done", 16'(done), 16'd1);
        chk("hold_prod", product, 16'd12);
      end
      if (k == 9) chk("hold_e9_idle", 16'(busy), 16'd0);
    end
    @(negedge clk); a = 8'd2; b = 8'd7;
    @(posedge clk); #1;
    chk("e10_accept", 16'(busy), 16'd1);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
    end
    chk("e10_done", 16'(done), 16'd1);
    chk("e10_prod", product, 16'd14);

    // asynchronous reset in the middle of CALC
    @(negedge clk); a = 8'd7; b = 8'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_prod", product, 16'h0000);
    chk("mid_rst_done", 16'(done), 16'd0);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    @(negedge clk); reset = 1'b0;
    do_op("m5x5", 8'd5, 8'd5, 16'd25, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/alu_mul.md
# alu_mul

Sequential signed 8×8 multiplier for the 8-bit ALU arithmetic unit. It is the multiply counterpart to the sequential divider and uses the same start/done handshake so both can share the ALU control FSM. It runs radix-2 Booth recoding over 8 iteration cycles and returns a registered 16-bit two's-complement product with a one-cycle `done` pulse.

## Interface
- No parameters; operand width is fixed at 8 bits, product width at 16 bits.
- `clk  input  1  rising-edge clock`
- `reset  input  1  asynchronous, active-high reset`
- `start  input  1  request; sampled only in IDLE`
- `a  input  8  signed multiplicand; captured on the accepting edge`
- `b  input  8  signed multiplier; captured on the accepting edge`
- `product  output  16  signed result, registered; holds its value until the next completion`
- `done  output  1  one-cycle pulse, registered; high in the cycle after `product` is written`
- `busy  output  1  high whenever state ≠ IDLE`

## Operation
- States: IDLE, CALC, DONE.
- **IDLE, start=1:**
  - Load accumulator A (9 bits) = 0.
  - Load Q = b and Q₋₁ = 0.
  - Load M = sign-extend(a) to 9 bits.
  - Load count = 0, then go to CALC.
- **IDLE, start=0:** stay in IDLE.
- **CALC, one Booth step per cycle:**
  - {Q[0],Q₋₁}=01: A ← A+M.
  - {Q[0],Q₋₁}=10: A ← A−M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,Q₋₁}, with A[8] replicated. Increment count.
- **CALC, count==7 at the edge (8th step):**
  - Write `product` ← {A[7:0],Q} using post-step values.
  - Set `done` ← 1 and go to DONE.
- **DONE:** clear `done` and return to IDLE unconditionally.
- Width rules:
  - 9-bit A guarantees −M never overflows, including M = −128.
  - The full-range result [−16256, 16384] fits in 16 bits signed, so there is no saturation.
- `start` in CALC or DONE is ignored; it is not queued.
- Operand changes after the accepting edge have no effect on the result.
- `product` is not cleared at start; it keeps the previous result until overwritten.
- **Reset (asynchronous, any state including mid-CALC):**
  - state = IDLE, `product` = 0, `done` = 0, `busy` = 0.
  - A, Q, Q₋₁, M and count are all cleared.
  - The in-flight operation is discarded.

## Timing
- Edge E0 (IDLE, start=1) accepts the operands; `busy` goes high after E0.
- Edges E1–E8 perform Booth steps 1–8.
- At E8, `product` and `done` are written. `done` is high from E8 to E9, which is 8 cycles of latency from the accepting edge.
- At E9, `done` falls and the state returns to IDLE; `busy` goes low after E9.
- The earliest next accepted start is at E10. Throughput is one result per 10 cycles with start held high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `ALU_MUL_ZERO_SKIP_EN`.
- **Defined:**
  - At the accepting edge, if a==0 or b==0: `product` ← 0, `done` ← 1, and go directly to DONE.
  - Latency for zero operands is 0 cycles after the accepting edge: `done` is high from E0 to E1, and the next start is accepted at E2.
  - Non-zero operands follow the normal 8-step path.
- **Not defined:**
  - Every operation, including zero operands, takes the full 8 steps.
  - The result is identical (0); only timing differs.

## Test plan
- Basic signed multiply: a=7, b=−3, start pulsed → `busy` high, `done` pulses exactly 8 cycles after the accepting edge, `product` = −21 (0xFFEB).
- Extreme operands:
  - a=−128, b=−128 → `product` = 16384 (0x4000).
  - a=127, b=−128 → −16256 (0xC080).
  - a=−1, b=1 → −1 (0xFFFF).
- Start and operands during operation: start held high and a/b changed every cycle during CALC → the first result is unaffected, and the second accept happens only at E10.
- Reset mid-operation: assert reset asynchronously during CALC step 4 → `product` = 0, `done` = 0, `busy` = 0 immediately. Then a=5, b=5 → 25 after 8 cycles.
- Zero operand: a=0, b=−77 →
  - with `ALU_MUL_ZERO_SKIP_EN`: `done` after E0, `product` = 0.
  - without it: `done` after E8, `product` = 0.
- Back-to-back: 12×11 followed by −9×9 → `product` 132 then −81. `product` holds 132 until the second `done`.
